// File: rtl/rgb_to_palette_index_if.sv
// Palette-write, pixel-in and index-out handshake bundle for rgb_to_palette_index.
interface rgb_to_palette_index_if #(
  parameter int unsigned CH_W = 4
);
  localparam int unsigned PIX_W  = 3 * CH_W;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DIST_W = 6;

  logic              pal_we;
  logic [IDX_W-1:0]  pal_waddr;
  logic [PIX_W-1:0]  pal_wdata;
  logic              pal_wr_err;

  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_rgb;

  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_index;
  logic [DIST_W-1:0] out_dist;
  logic              out_exact;

  modport master (
    output pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    input  pal_wr_err, in_ready, out_valid, out_index, out_dist, out_exact
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    output pal_wr_err, in_ready, out_valid, out_index, out_dist, out_exact
  );
endinterface

// File: rtl/rgb_to_palette_index.sv
// Nearest-colour search of a 12-bit RGB pixel against a loadable 16-entry palette,
// one entry per cycle, Manhattan distance, ties resolved to the lower index.
module rgb_to_palette_index #(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned CH_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_to_palette_index_if.slave bus
);
  localparam int unsigned PIX_W  = 3 * CH_W;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DIST_W = 6;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t             state;
  logic [PIX_W-1:0]   pal [N_ENTRIES];
  logic [PIX_W-1:0]   pix;
  logic [IDX_W-1:0]   k;
  logic [IDX_W-1:0]   best_idx;
  logic [DIST_W-1:0]  best_dist;

  logic [PIX_W-1:0]   entry_c;
  logic [CH_W-1:0]    dr_c, dg_c, db_c;
  logic [DIST_W-1:0]  dist_c;
  logic               better_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [DIST_W-1:0]  win_dist_c;

  function automatic logic [CH_W-1:0] absdiff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Distance of the latched pixel to entry k, folded into the running best.
  always_comb begin
    entry_c    = pal[k];
    dr_c       = absdiff(pix[PIX_W-1 -: CH_W],   entry_c[PIX_W-1 -: CH_W]);
    dg_c       = absdiff(pix[2*CH_W-1 -: CH_W],  entry_c[2*CH_W-1 -: CH_W]);
    db_c       = absdiff(pix[CH_W-1:0],          entry_c[CH_W-1:0]);
    dist_c     = DIST_W'(dr_c) + DIST_W'(dg_c) + DIST_W'(db_c);
    better_c   = (dist_c < best_dist);
    win_idx_c  = better_c ? k : best_idx;
    win_dist_c = better_c ? dist_c : best_dist;
  end

  assign bus.in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pix            <= '0;
      k              <= '0;
      best_idx       <= '0;
      best_dist      <= '1;
      bus.out_valid  <= 1'b0;
      bus.out_index  <= '0;
      bus.out_dist   <= '0;
      bus.out_exact  <= 1'b0;
      bus.pal_wr_err <= 1'b0;
      for (int i = 0; i < int'(N_ENTRIES); i++) pal[i] <= '0;
    end else begin
      // Palette is frozen outside IDLE so a search always sees one consistent table.
      bus.pal_wr_err <= bus.pal_we & (state != IDLE);
      if (bus.pal_we && state == IDLE) pal[bus.pal_waddr] <= bus.pal_wdata;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pix       <= bus.in_rgb;
            k         <= '0;
            best_idx  <= '0;
            best_dist <= '1;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          best_idx  <= win_idx_c;
          best_dist <= win_dist_c;
          k         <= k + IDX_W'(1);
          if (k == IDX_W'(N_ENTRIES - 1)) begin
            bus.out_valid <= 1'b1;
            bus.out_index <= win_idx_c;
            bus.out_dist  <= win_dist_c;
            bus.out_exact <= (win_dist_c == '0);
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
